instruction_memory_pipelined: RTL and testbench
===============================================

INSTRUCTION_MEMORY_PIPELINED -- requirements
Module: instruction_memory_pipelined

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, instruction word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 8, address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 256, number of words; legal range 1..2**ADDR_W.
REQ-004 The block SHALL have parameter INIT_FILE, default "" (none), hex image preloaded at elaboration.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 The block SHALL have port req_valid, input, 1, fetch request present.
REQ-008 The block SHALL have port req_ready, output, 1, block accepts a request this cycle.
REQ-009 The block SHALL have port req_addr, input, ADDR_W, word address of the fetch.
REQ-010 The block SHALL have port rsp_valid, output, 1, rsp_instr/rsp_err hold a response.
REQ-011 The block SHALL have port rsp_ready, input, 1, consumer takes the response this cycle.
REQ-012 The block SHALL have port rsp_instr, output, DATA_W, fetched instruction word.
REQ-013 The block SHALL have port rsp_err, output, 1, fetched address was >= DEPTH.
REQ-014 The block SHALL have port prog_we, input, 1, program-load write strobe.
REQ-015 The block SHALL have port prog_addr, input, ADDR_W, program-load word address.
REQ-016 The block SHALL have port prog_data, input, DATA_W, program-load data.

Function
REQ-017 The block SHALL accept a request on a cycle where req_valid and req_ready are both 1.
REQ-018 An accepted request SHALL produce rsp_valid=1 with its data on the next cycle: latency 1.
REQ-019 The block SHALL return responses in request order, each exactly once.
REQ-020 The response path SHALL be a 2-entry buffer (output register + skid) with states EMPTY, ONE, TWO.
REQ-021 Transitions SHALL be: EMPTY→ONE on accept; ONE→TWO on accept without rsp_ready; ONE→EMPTY on rsp_ready without accept; TWO→ONE on rsp_ready (no accept possible); all other combinations hold state.
REQ-022 req_ready SHALL be 1 in EMPTY and ONE and 0 in TWO; it SHALL depend only on registered state, not on rsp_ready.
REQ-023 Once rsp_valid is 1, rsp_instr and rsp_err SHALL stay stable until rsp_ready is 1.
REQ-024 In TWO with rsp_ready=1, the skid entry SHALL move to the output register on the next cycle.
REQ-025 A fetch of req_addr >= DEPTH SHALL return rsp_instr=0 and rsp_err=1; an in-range fetch SHALL return rsp_err=0.
REQ-026 prog_we=1 with prog_addr < DEPTH SHALL write prog_data at the rising edge; prog_addr >= DEPTH SHALL be ignored.
REQ-027 A fetch and a write to the same address in the same cycle SHALL return the old contents (read-first).
REQ-028 Writes SHALL be accepted in every state, including TWO and during rst.
REQ-029 Words not preloaded SHALL read as 0 in simulation; with INIT_FILE empty, all words are 0.

Reset
REQ-030 rst=1 SHALL force the state to EMPTY, rsp_valid=0, rsp_instr=0, rsp_err=0, and req_ready=1 from the following cycle.
REQ-031 Reset SHALL discard any buffered or in-flight response; no response to a pre-reset request SHALL appear.
REQ-032 Memory contents SHALL NOT be affected by rst.

Structure
REQ-033 Default widths, DEPTH and the state encoding (EMPTY/ONE/TWO) SHALL live in shared package cpu_pkg.
REQ-034 The response buffering SHALL be a sub-module named skid_buffer, parametrised on payload width DATA_W+1.
REQ-035 The storage array SHALL be a single synchronous-read memory, inferable as block RAM.

Verification
REQ-036 Reset, then preload word 0..3 = 1,2,3,4, fetch addr 2 with rsp_ready=1 → next cycle rsp_valid=1, rsp_instr=3, rsp_err=0.
REQ-037 Hold rsp_ready=0 and issue fetches at 0, 1, 2 → req_ready=0 after two accepts; with rsp_ready=1, the bench receives 1 then 2; the third fetch (addr 2) is then accepted.
REQ-038 With DEPTH=200, fetch addr 250 → rsp_instr=0, rsp_err=1; prog_we at addr 250 → no memory word changes.
REQ-039 In the same cycle, prog_we to addr 1 with 0xDEADBEEF and fetch addr 1 → returns 2; a following fetch of addr 1 returns 0xDEADBEEF.
REQ-040 Assert rst while in TWO → next cycle rsp_valid=0, req_ready=1, and neither buffered word is ever delivered.
REQ-041 Random req_valid/rsp_ready for 10000 cycles → responses match a reference-model queue in order with no loss or duplication.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared defaults and response-buffer state encoding
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH_DEF  = 256;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - two-entry response buffer (output register + skid)
module skid_buffer
  import cpu_pkg::*;
#(
  parameter int W = DATA_W_DEF + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_tvalid,
  output logic         up_tready,
  input  logic [W-1:0] up_tdata,
  output logic         dn_tvalid,
  input  logic         dn_tready,
  output logic [W-1:0] dn_tdata
);

  // up_tdata is the payload of the most recent push, presented from the cycle
  // after that push and held by the source until the next push. The newest
  // entry therefore always lives upstream; only the older one is stored here.
  buf_state_t   state, state_nxt;
  logic [W-1:0] held_q;
  logic         push, pop, spill;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (spill) held_q <= up_tdata;
  end

  always_comb begin
    state_nxt = state;
    up_tready = 1'b0;
    dn_tvalid = 1'b0;
    dn_tdata  = '0;
    push      = 1'b0;
    pop       = 1'b0;
    spill     = 1'b0;
    case (state)
      ST_EMPTY: begin
        up_tready = 1'b1;
        push      = up_tvalid;
        if (push) state_nxt = ST_ONE;
      end
      ST_ONE: begin
        up_tready = 1'b1;
        dn_tvalid = 1'b1;
        dn_tdata  = up_tdata;
        push      = up_tvalid;
        pop       = dn_tready;
        if (push && !pop) begin
          state_nxt = ST_TWO;
          spill     = 1'b1;
        end else if (!push && pop) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        dn_tvalid = 1'b1;
        dn_tdata  = held_q;
        pop       = dn_tready;
        if (pop) state_nxt = ST_ONE;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

endmodule

// File: rtl/instruction_memory_pipelined.sv
// rtl/instruction_memory_pipelined.sv - synchronous instruction ROM/RAM with buffered fetch responses
module instruction_memory_pipelined
  import cpu_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic              rsp_err,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  typedef logic [DATA_W-1:0] mem_t [DEPTH];

  mem_t mem = '{default: '0};

  logic              accept;
  logic              req_in_range, prog_in_range;
  logic [DATA_W-1:0] rd_q;
  logic              rd_err_q;
  logic [DATA_W:0]   rd_payload, rsp_payload;

  assign accept        = req_valid & req_ready;
  assign req_in_range  = {1'b0, req_addr}  < DEPTH_LIM;
  assign prog_in_range = {1'b0, prog_addr} < DEPTH_LIM;

  // Writes are independent of rst and of the response buffer state.
  always_ff @(posedge clk) begin
    if (prog_we && prog_in_range) mem[prog_addr] <= prog_data;
  end

  // Enabled read register: holds the newest accepted fetch until the next
  // accept, which is what the skid buffer relies on. Reads see pre-write data.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_q     <= mem[req_addr];
      rd_err_q <= !req_in_range;
    end
  end

  assign rd_payload = {rd_err_q, rd_err_q ? {DATA_W{1'b0}} : rd_q};

  skid_buffer #(
    .W(DATA_W + 1)
  ) u_rsp_buf (
    .clk      (clk),
    .rst      (rst),
    .up_tvalid(req_valid),
    .up_tready(req_ready),
    .up_tdata (rd_payload),
    .dn_tvalid(rsp_valid),
    .dn_tready(rsp_ready),
    .dn_tdata (rsp_payload)
  );

  assign rsp_err   = rsp_payload[DATA_W];
  assign rsp_instr = rsp_payload[DATA_W-1:0];

endmodule

// File: tb/tb_instruction_memory_pipelined.sv
// tb/tb_instruction_memory_pipelined.sv - randomized and directed checks against a queue model
module tb_instruction_memory_pipelined;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int DP = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_instr;
  logic          rsp_err;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [DW-1:0] prog_data = '0;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] mm [256];
  logic [DW:0]   exp_q [$];

  always #5 clk = ~clk;

  instruction_memory_pipelined #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_err(rsp_err),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  // Model: at most two outstanding responses, delivered in order; fetches see
  // memory contents before any same-cycle write; reset drops everything queued.
  task automatic tick();
    bit acc, pp;
    acc = req_valid && (exp_q.size() < 2);
    pp  = rsp_ready && (exp_q.size() > 0);
    if (pp) void'(exp_q.pop_front());
    if (acc) begin
      if (int'(req_addr) < DP) exp_q.push_back({1'b0, mm[req_addr]});
      else                     exp_q.push_back({1'b1, {DW{1'b0}}});
    end
    if (prog_we && int'(prog_addr) < DP) mm[prog_addr] = prog_data;
    if (rst) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors += 4;
    if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    if (rsp_instr !== '0)   begin miscompares++; $display("FAIL reset_rsp_instr: got %h expected 0", rsp_instr); end
    if (rsp_err !== 1'b0)   begin miscompares++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
  endtask

  task automatic preload();
    for (int i = 0; i < 4; i++) begin
      prog_we = 1'b1; prog_addr = AW'(i); prog_data = DW'(i + 1);
      tick();
    end
    prog_we = 1'b0;
  endtask

  task automatic test_basic_fetch();
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 8'd2;
    tick();
    req_valid = 1'b0;
    vectors += 3;
    if (rsp_valid !== 1'b1)   begin miscompares++; $display("FAIL basic_valid: got %b expected 1", rsp_valid); end
    if (rsp_instr !== 32'd3)  begin miscompares++; $display("FAIL basic_instr: got %h expected 3", rsp_instr); end
    if (rsp_err !== 1'b0)     begin miscompares++; $display("FAIL basic_err: got %b expected 0", rsp_err); end
    tick();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 8'd0;
    tick();
    req_addr = 8'd1;
    tick();
    req_addr = 8'd2;
    vectors += 2;
    if (req_ready !== 1'b0)  begin miscompares++; $display("FAIL bp_full_ready: got %b expected 0", req_ready); end
    if (rsp_instr !== 32'd1) begin miscompares++; $display("FAIL bp_first: got %h expected 1", rsp_instr); end
    tick();
    vectors++;
    if (rsp_instr !== 32'd1) begin miscompares++; $display("FAIL bp_stable: got %h expected 1", rsp_instr); end
    rsp_ready = 1'b1;
    tick();
    vectors += 2;
    if (rsp_instr !== 32'd2) begin miscompares++; $display("FAIL bp_second: got %h expected 2", rsp_instr); end
    if (req_ready !== 1'b1)  begin miscompares++; $display("FAIL bp_reopen: got %b expected 1", req_ready); end
    tick();
    req_valid = 1'b0;
    vectors += 2;
    if (rsp_valid !== 1'b1)  begin miscompares++; $display("FAIL bp_third_valid: got %b expected 1", rsp_valid); end
    if (rsp_instr !== 32'd3) begin miscompares++; $display("FAIL bp_third: got %h expected 3", rsp_instr); end
    tick();
    vectors++;
    if (rsp_valid !== 1'b0)  begin miscompares++; $display("FAIL bp_drained: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_out_of_range();
    rsp_ready = 1'b1;
    prog_we = 1'b1; prog_addr = 8'd250; prog_data = 32'hA5A5_5A5A;
    req_valid = 1'b1; req_addr = 8'd250;
    tick();
    prog_we = 1'b0; req_valid = 1'b0;
    vectors += 2;
    if (rsp_err !== 1'b1)   begin miscompares++; $display("FAIL oor_err: got %b expected 1", rsp_err); end
    if (rsp_instr !== '0)   begin miscompares++; $display("FAIL oor_instr: got %h expected 0", rsp_instr); end
    tick();
    req_valid = 1'b1;
    for (int a = 0; a < DP; a++) begin
      req_addr = AW'(a);
      tick();
      vectors++;
      if ({rsp_err, rsp_instr} !== exp_q[0] || exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL oor_scan[%0d]: got %b/%h expected %h", a, rsp_err, rsp_instr, exp_q[0]);
      end
    end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_read_first();
    rsp_ready = 1'b1;
    prog_we = 1'b1; prog_addr = 8'd1; prog_data = 32'hDEAD_BEEF;
    req_valid = 1'b1; req_addr = 8'd1;
    tick();
    prog_we = 1'b0;
    vectors++;
    if (rsp_instr !== 32'd2) begin miscompares++; $display("FAIL rf_old: got %h expected 2", rsp_instr); end
    tick();
    req_valid = 1'b0;
    vectors++;
    if (rsp_instr !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rf_new: got %h expected deadbeef", rsp_instr); end
    tick();
  endtask

  task automatic test_reset_in_two();
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 8'd0;
    tick();
    req_addr = 8'd3;
    tick();
    req_valid = 1'b0;
    vectors++;
    if (req_ready !== 1'b0) begin miscompares++; $display("FAIL r2_full: got %b expected 0", req_ready); end
    rst = 1'b1;
    prog_we = 1'b1; prog_addr = 8'd7; prog_data = 32'h0BAD_F00D;
    tick();
    rst = 1'b0; prog_we = 1'b0;
    vectors += 2;
    if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL r2_valid: got %b expected 0", rsp_valid); end
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL r2_ready: got %b expected 1", req_ready); end
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL r2_ghost[%0d]: got %b expected 0", i, rsp_valid); end
    end
    req_valid = 1'b1; req_addr = 8'd7;
    tick();
    req_valid = 1'b0;
    vectors++;
    if (rsp_instr !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL r2_write_in_rst: got %h expected 0badf00d", rsp_instr); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 10000; c++) begin
      req_valid = $urandom_range(0, 3) != 0;
      rsp_ready = $urandom_range(0, 2) != 0;
      req_addr  = AW'($urandom_range(0, 255));
      prog_we   = $urandom_range(0, 7) == 0;
      prog_addr = AW'($urandom_range(0, 255));
      prog_data = $urandom;
      vectors += 2;
      if (rsp_valid !== (exp_q.size() > 0)) begin
        miscompares++; $display("FAIL rnd_valid@%0d: got %b expected %b", c, rsp_valid, exp_q.size() > 0);
      end
      if (req_ready !== (exp_q.size() < 2)) begin
        miscompares++; $display("FAIL rnd_ready@%0d: got %b expected %b", c, req_ready, exp_q.size() < 2);
      end
      if (exp_q.size() > 0) begin
        vectors++;
        if ({rsp_err, rsp_instr} !== exp_q[0]) begin
          miscompares++; $display("FAIL rnd_data@%0d: got %b/%h expected %h", c, rsp_err, rsp_instr, exp_q[0]);
        end
      end
      tick();
    end
    req_valid = 1'b0; prog_we = 1'b0; rsp_ready = 1'b1;
    tick(); tick(); tick();
    vectors++;
    if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rnd_drain: got %b expected 0", rsp_valid); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mm[i] = '0;
    @(posedge clk);
    #1;
    test_reset();
    preload();
    test_basic_fetch();
    test_backpressure();
    test_out_of_range();
    test_read_first();
    test_reset_in_two();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
